// File: rtl/fifo_pkg.sv
// Shared sizing and types for the FIFO RAM controller.
package fifo_pkg;

    localparam int unsigned ADDR_W        = 5;
    localparam int unsigned DEPTH         = 2 ** ADDR_W;
    localparam int unsigned PTR_W         = ADDR_W + 1;
    localparam int unsigned AF_THRESH_DEF = 28;
    localparam int unsigned AE_THRESH_DEF = 4;

    typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer register: increments on inc, cleared by flush or reset. MSB is the wrap bit.
module fifo_ptr
    import fifo_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic flush,
    input  logic inc,
    output ptr_t ptr
);

    ptr_t ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (flush) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ram_ctrl.sv
// Synchronous FIFO controller for a 32x32 dual-port RAM: addresses, enables, occupancy and
// sticky error flags.
module fifo_ram_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned AF_THRESH = AF_THRESH_DEF,
    parameter int unsigned AE_THRESH = AE_THRESH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic             flush,
    input  logic             clr_err,
    output logic [PTR_W-1:0] ram_wptr,
    output logic [PTR_W-1:0] ram_rptr,
    output logic             ram_we,
    output logic             ram_re,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0] AfLevel = (PTR_W + 1)'(AF_THRESH);
    localparam logic [PTR_W:0] AeLevel = (PTR_W + 1)'(AE_THRESH);

    ptr_t wptr, rptr, occ;
    logic wr_ok, rd_ok;
    logic rd_valid_q, rd_valid_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    fifo_ptr u_wptr (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .inc    (wr_ok),
        .ptr    (wptr)
    );

    fifo_ptr u_rptr (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .inc    (rd_ok),
        .ptr    (rptr)
    );

    assign occ   = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign count        = {1'b0, occ};
    assign almost_full  = (count >= AfLevel);
    assign almost_empty = (count <= AeLevel);

    // Enables are held off while reset is asserted.
    assign wr_ok  = resetn & wr_req & ~full & ~flush;
    assign rd_ok  = resetn & rd_req & ~empty & ~flush;
    assign ram_we = wr_ok;
    assign ram_re = rd_ok;

    assign ram_wptr = {1'b0, wptr[ADDR_W-1:0]};
    assign ram_rptr = {1'b0, rptr[ADDR_W-1:0]};

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        rd_valid_d  = rd_ok;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // A new error in the same cycle as clr_err wins.
        if (wr_req && full && !flush) begin
            overflow_d = 1'b1;
        end
        if (rd_req && empty && !flush) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/fifo_ram_ctrl.md
Name: fifo_ram_ctrl

Overview:
Single-clock controller that sequences the dual-port 32x32 FIFO RAM as a synchronous FIFO. It accepts write/read requests, generates RAM addresses and enables, and tracks occupancy, almost thresholds and sticky error flags. It also provides a one-cycle flush. It sits between producer/consumer logic and the RAM instance; both RAM clocks are tied to clk.

Parameters:
ADDR_W, 5, RAM address width; depth = 2**ADDR_W = 32
AF_THRESH, 28, almost_full asserted when count >= AF_THRESH
AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH

Ports:
clk  in  1  single clock; drives controller and both RAM clocks
resetn  in  1  synchronous reset, active-low
wr_req  in  1  producer write request; data is on RAM wd the same cycle
rd_req  in  1  consumer read request
flush  in  1  synchronous clear of pointers and count
clr_err  in  1  clears sticky overflow/underflow
ram_wptr  out  6  RAM write address = {1'b0, wptr[ADDR_W-1:0]}
ram_rptr  out  6  RAM read address = {1'b0, rptr[ADDR_W-1:0]}
ram_we  out  1  RAM writeEnable (combinational)
ram_re  out  1  RAM readEnable (combinational)
rd_valid  out  1  RAM rd holds popped word (registered)
full  out  1  count == 32
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  7  occupancy, 0..32
overflow  out  1  sticky: wr_req seen while full
underflow  out  1  sticky: rd_req seen while empty

Behaviour:
- Internal wptr/rptr are ADDR_W+1 = 6 bits; the MSB is the wrap bit. The RAM always sees MSB forced to 0, so the address stays within 0..31.
- Status decode:
  - empty: wptr == rptr.
  - full: MSBs differ and low bits are equal.
  - count = wptr - rptr, mod 64, zero-extended to 7 bits.
- Accept rules (combinational):
  - wr_ok = wr_req & ~full & ~flush.
  - rd_ok = rd_req & ~empty & ~flush.
  - ram_we = wr_ok; ram_re = rd_ok.
- On each clk edge:
  - wptr += wr_ok; rptr += rd_ok.
  - Pointers wrap naturally at 64, so the low address wraps 31->0 and the wrap bit toggles.
- Simultaneous wr_req & rd_req:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write rejected (no pass-through); overflow sets.
  - Empty: write accepted, read rejected (no bypass); underflow sets.
- Read latency: the RAM registers rd. rd_valid <= rd_ok, so rd_valid is high the cycle after ram_re and the word is on rd in that cycle.
- Sticky flags:
  - overflow <= 1 when wr_req & full & ~flush.
  - underflow <= 1 when rd_req & empty & ~flush.
  - clr_err clears both; if a set and clr_err coincide, set wins.
- flush: wptr, rptr, rd_valid <= 0 next edge; all requests that cycle are ignored; sticky flags are unchanged.
- Reset (resetn == 0 at clk edge):
  - wptr = rptr = 0, rd_valid = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0.
  - Enables are 0 while reset is low.
  - Reset mid-operation discards all contents logically; RAM data is not cleared.
- All status outputs are combinational decodes of the registered pointers. There are no status glitches between edges other than those caused by request inputs on ram_we/ram_re.

Decomposition:
- Shared package fifo_pkg: ADDR_W, DEPTH, PTR_W = ADDR_W+1, default thresholds, and a ptr_t typedef (PTR_W bits).
- One natural sub-module, fifo_ptr: a pointer register with increment enable and flush/reset, instantiated twice (write and read).
- Status decode and sticky flags remain in fifo_ram_ctrl.
- Top-level integration instantiates RAM with clkw = clkr = clk and resetw = resetr = ~resetn.

Test Plan:
- Reset, then write 32 words (0x1000+i) back-to-back -> count steps 1..32; almost_full rises at count 28; full = 1 after the 32nd write, with ram_wptr having walked 0..31.
- Drain the full FIFO with 32 reads -> rd_valid one cycle after each ram_re; rd sequence 0x1000..0x101F; empty = 1 at the end; almost_empty rises at count 4.
- Fill to 32, then wr_req & rd_req together -> ram_we = 0, ram_re = 1, count = 31, overflow = 1; then clr_err -> overflow = 0.
- Empty FIFO, wr_req & rd_req together -> ram_we = 1, ram_re = 0, count = 1, underflow = 1, rd_valid stays 0.
- Wrap: push/pop in lockstep for 100 cycles at count 5 -> count constant at 5; ram_wptr wraps 31->0 and data order is preserved across the wrap.
- Count 10, assert flush with wr_req = 1 -> next cycle count = 0, empty = 1, no write issued. Separately, drop resetn mid-burst -> next edge count = 0, rd_valid = 0, flags = 0.
